// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl
//   Wide (WIDTH*WORDS-bit) add/subtract built from a single WIDTH-bit ripple
//   adder that is reused once per cycle, least-significant word first, with
//   the carry held in a register between cycles.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, cin, sub)
//   a, b                 N-bit operands, N = WIDTH*WORDS
//   cin                  carry-in for add (ignored for subtract)
//   sub                  0: a+b+cin   1: a-b
//   busy                 operation in progress (RUN or DONE)
//   out_valid/out_ready  result handshake (sum, cout, ovf)
//   sum, cout, ovf       result, carry out of MSB, signed overflow
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// RUN   | one word per cycle through the adder
// DONE  | result held until the consumer takes it

module ripple_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    always_comb begin
        logic c;
        c     = i_cin;
        o_sum = '0;
        for (int k = 0; k < WIDTH; k++) begin
            o_sum[k] = i_a[k] ^ i_b[k] ^ c;
            c        = (i_a[k] & i_b[k]) | (c & (i_a[k] ^ i_b[k]));
        end
        o_cout = c;
    end
endmodule

module multiword_add_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);
    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_cy;
    logic [N-1:0]      r_opa;
    logic [N-1:0]      r_opb;
    logic [N-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [WIDTH-1:0]  w_a_word;
    logic [WIDTH-1:0]  w_b_word;
    logic [WIDTH-1:0]  w_add_sum;
    logic              w_add_cout;
    logic              w_last;

    // Word select by compare rather than a variable part-select keeps the
    // mux width-clean for any WORDS.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_word = r_opa[k*WIDTH +: WIDTH];
                w_b_word = r_opb[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_last = (r_idx == IDXW'(WORDS - 1));

    ripple_add #(.WIDTH(WIDTH)) u_add (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_cy),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cy        <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtract is A + ~B + 1: invert B once here and
                        // seed the carry chain with 1.
                        r_opa      <= a;
                        r_opb      <= sub ? ~b : b;
                        r_cy       <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_sum[k*WIDTH +: WIDTH] <= w_add_sum;
                        end
                    end
                    r_cy  <= w_add_cout;
                    r_idx <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout      <= w_add_cout;
                        // opB MSB is already inverted for subtract
                        r_ovf       <= (r_opa[N-1] == r_opb[N-1]) &&
                                       (w_add_sum[WIDTH-1] != r_opa[N-1]);
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule
